// File: rtl/queue_occupancy_counter.sv
// Queue occupancy counter: synchronises and debounces the entry/exit sensors, turns rising
// edges into events and keeps a saturating occupancy, sticky error flags and a served total.
module queue_occupancy_counter #(
    parameter int unsigned N           = 3,
    parameter int unsigned MAX_COUNT   = 7,
    parameter int unsigned AFULL_LEVEL = 6,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned SERVED_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sensor_a,
    input  logic                sensor_b,
    input  logic                clr_err,
    output logic [N-1:0]        pcount,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                entry_pulse,
    output logic                exit_pulse,
    output logic                reject_err,
    output logic                underflow_err,
    output logic [SERVED_W-1:0] served_cnt
);

    localparam int unsigned    CntW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
    localparam logic [N-1:0]    MaxCnt  = N'(MAX_COUNT);
    localparam logic [N-1:0]    AfLvl   = N'(AFULL_LEVEL);

    // Bit 0 is the entry sensor path, bit 1 the exit sensor path.
    logic [1:0]      sync1_q, s2_q, filt_q, filt_dly_q;
    logic [CntW-1:0] db_cnt_q [2];
    logic [1:0]      rise;

    logic [N-1:0]        pcount_d;
    logic [SERVED_W-1:0] served_d;
    logic                rej_set, und_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            s2_q       <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= {sensor_b, sensor_a};
            s2_q       <= sync1_q;
            filt_dly_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CntLast) begin
                    filt_q[i]   <= s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = filt_q & ~filt_dly_q;

    always_comb begin
        pcount_d = pcount;
        served_d = served_cnt;
        rej_set  = 1'b0;
        und_set  = 1'b0;
        case (rise)
            2'b11: served_d = served_cnt + 1'b1;  // simultaneous: occupancy unchanged
            2'b01: begin
                if (pcount < MaxCnt) pcount_d = pcount + 1'b1;
                else                 rej_set  = 1'b1;
            end
            2'b10: begin
                if (pcount != '0) begin
                    pcount_d = pcount - 1'b1;
                    served_d = served_cnt + 1'b1;
                end else begin
                    und_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcount        <= '0;
            served_cnt    <= '0;
            entry_pulse   <= 1'b0;
            exit_pulse    <= 1'b0;
            reject_err    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pcount        <= pcount_d;
            served_cnt    <= served_d;
            entry_pulse   <= rise[0];
            exit_pulse    <= rise[1];
            // A new error outranks a simultaneous clear.
            reject_err    <= rej_set | (reject_err & ~clr_err);
            underflow_err <= und_set | (underflow_err & ~clr_err);
        end
    end

    assign full        = (pcount == MaxCnt);
    assign empty       = (pcount == '0);
    assign almost_full = (pcount >= AfLvl);

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Directed bench for queue_occupancy_counter (MAX_COUNT=5, AFULL_LEVEL=4, SERVED_W=2).
module tb_queue_occupancy_counter;

    logic       clk = 1'b0;
    logic       rst, sensor_a, sensor_b, clr_err;
    logic [2:0] pcount;
    logic       full, empty, almost_full, entry_pulse, exit_pulse;
    logic       reject_err, underflow_err;
    logic [1:0] served_cnt;

    int total = 0;
    int bad   = 0;
    int na, nb;
    int exp_served [5] = '{1, 2, 3, 0, 1};

    queue_occupancy_counter #(
        .N          (3),
        .MAX_COUNT  (5),
        .AFULL_LEVEL(4),
        .DB_CYCLES  (4),
        .SERVED_W   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_a     (sensor_a),
        .sensor_b     (sensor_b),
        .clr_err      (clr_err),
        .pcount       (pcount),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .reject_err   (reject_err),
        .underflow_err(underflow_err),
        .served_cnt   (served_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pcount"}, pcount, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_entry"}, entry_pulse, 0);
        check({tag, "_exit"}, exit_pulse, 0);
        check({tag, "_rej"}, reject_err, 0);
        check({tag, "_und"}, underflow_err, 0);
        check({tag, "_served"}, served_cnt, 0);
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        for (int i = 0; i < n; i++) begin
            tick();
            na += int'(entry_pulse);
            nb += int'(exit_pulse);
        end
    endtask

    // One clean event per asserted sensor: high long enough to debounce, then low again.
    task automatic ev(input logic a, input logic b);
        na = 0;
        nb = 0;
        hold(a, b, 8);
        hold(1'b0, 1'b0, 8);
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; clr_err = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        // Basic entry: pulse exactly on the 7th edge after the rise, only once.
        sensor_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("basic_pulse", entry_pulse, (i == 7));
            if (i == 6) check("basic_pcount_pre", pcount, 0);
            if (i == 7) begin
                check("basic_pcount", pcount, 1);
                check("basic_empty", empty, 0);
            end
        end
        na = 0;
        hold(1'b0, 1'b0, 12);
        check("basic_fall_none", na, 0);

        // Glitches.
        na = 0;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 15);
        check("glitch3_events", na, 0);
        check("glitch3_pcount", pcount, 1);
        na = 0;
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 15);
        check("pulse4_events", na, 1);
        check("pulse4_pcount", pcount, 2);

        // Fill past capacity.
        ev(1'b1, 1'b0);
        check("fill3_pcount", pcount, 3);
        check("fill3_afull", almost_full, 0);
        ev(1'b1, 1'b0);
        check("fill4_pcount", pcount, 4);
        check("fill4_afull", almost_full, 1);
        check("fill4_full", full, 0);
        ev(1'b1, 1'b0);
        check("fill5_pcount", pcount, 5);
        check("fill5_full", full, 1);
        check("fill5_rej", reject_err, 0);
        ev(1'b1, 1'b0);
        check("fill6_pulse", na, 1);
        check("fill6_pcount", pcount, 5);
        check("fill6_rej", reject_err, 1);
        clear_errs();
        check("clr_rej", reject_err, 0);

        // Rejected entry lands on the same edge as clr_err: set wins.
        na = 0;
        hold(1'b1, 1'b0, 6);
        clr_err = 1'b1;
        hold(1'b1, 1'b0, 1);
        clr_err = 1'b0;
        check("setwin_pulse", entry_pulse, 1);
        check("setwin_rej", reject_err, 1);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 8);
        clear_errs();

        // Drain with served wrap at 2 bits.
        for (int i = 0; i < 5; i++) begin
            ev(1'b0, 1'b1);
            check("drain_pcount", pcount, 32'(4 - i));
            check("drain_served", served_cnt, exp_served[i]);
        end
        check("drain_empty", empty, 1);

        // Underflow.
        ev(1'b0, 1'b1);
        check("und_pulse", nb, 1);
        check("und_pcount", pcount, 0);
        check("und_flag", underflow_err, 1);
        check("und_served", served_cnt, 1);
        clear_errs();
        check("clr_und", underflow_err, 0);

        // Simultaneous events at 0, 3 and MAX_COUNT.
        ev(1'b1, 1'b1);
        check("sim0_pcount", pcount, 0);
        check("sim0_served", served_cnt, 2);
        check("sim0_und", underflow_err, 0);
        check("sim0_rej", reject_err, 0);
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b1);
        check("sim3_pulses", na + nb, 2);
        check("sim3_pcount", pcount, 3);
        check("sim3_served", served_cnt, 3);
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b1);
        check("sim5_pcount", pcount, 5);
        check("sim5_served", served_cnt, 0);
        check("sim5_rej", reject_err, 0);
        check("sim5_und", underflow_err, 0);

        // Reset in the middle of an exit debounce.
        hold(1'b0, 1'b1, 4);
        rst = 1'b1;
        sensor_b = 1'b0;
        tick();
        tick();
        check_reset("midrst");
        rst = 1'b0;
        na = 0;
        nb = 0;
        hold(1'b0, 1'b0, 12);
        check("midrst_events", na + nb, 0);
        check("midrst_pcount", pcount, 0);

        // Sensor held high through reset release.
        sensor_b = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("rstrel_pulse", exit_pulse, (i == 7));
        end
        check("rstrel_und", underflow_err, 1);
        check("rstrel_served", served_cnt, 0);
        hold(1'b0, 1'b0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
